top_if_stage: RTL and testbench
===============================

TOP_IF_STAGE -- requirements
Module: top_if_stage

Interface
REQ-001 Parameter RAM_WIDTH_PROGRAMA, default 32: instruction/data word width.
REQ-002 Parameter RAM_PERFORMANCE_PROGRAMA, default "LOW_LATENCY": "LOW_LATENCY" gives 1-cycle read, "HIGH_PERFORMANCE" adds an output register (2-cycle read).
REQ-003 Parameter INIT_FILE_PROGRAMA, default "": hex init file; empty means all words 0 (NOP).
REQ-004 Parameter RAM_DEPTH_PROGRAMA, default 2048: words of program memory.
REQ-005 Parameter CANT_BITS_ADDR, default 11: address/PC width, clog2(depth).
REQ-006 Ports, one clock; reset is synchronous and active-high:
- i_clock  in  1  clock, all logic on rising edge
- i_soft_reset  in  1  synchronous active-high reset
- i_enable_contador_PC  in  1  PC update enable
- i_enable_mem  in  1  memory port enable
- i_write_read_mem  in  1  1 = write, 0 = read
- i_rsta_mem  in  1  memory output-latch reset
- i_regcea_mem  in  1  output-register clock enable (HIGH_PERFORMANCE only)
- i_addr_mem_programa  in  CANT_BITS_ADDR  debug/load address
- i_data_mem_programa  in  RAM_WIDTH_PROGRAMA  write data
- i_control_mux_PC  in  1  0 = sequential, 1 = branch
- i_control_mux_addr_mem  in  1  0 = PC addresses memory, 1 = i_addr_mem_programa
- i_control_mux_ouput  in  1  1 = force NOP on o_instruction
- i_branch_dir  in  CANT_BITS_ADDR  branch target word address
- o_instruction  out  RAM_WIDTH_PROGRAMA  fetched instruction
- o_direccion_PC_PLUS_4  out  CANT_BITS_ADDR  PC+1 (next sequential word)
- o_contador_programa  out  CANT_BITS_ADDR  current PC
- o_led_mem  out  1  write-activity indicator
- o_reset_ack_mem  out  1  output-latch reset acknowledge

Function
REQ-007 PC is a word address; o_direccion_PC_PLUS_4 = PC+1 combinational, modulo 2^CANT_BITS_ADDR (2047 wraps to 0).
REQ-008 On a clock edge with i_enable_contador_PC=1 and not halted: PC <= i_branch_dir if i_control_mux_PC=1, else PC+1; otherwise PC holds.
REQ-009 Memory address = i_addr_mem_programa when i_control_mux_addr_mem=1, else PC.
REQ-010 Write: i_enable_mem=1 and i_write_read_mem=1 stores i_data_mem_programa at the selected address on the edge; read output is unchanged during a write (no read-first/write-through).
REQ-011 Read: i_enable_mem=1 and i_write_read_mem=0 latches mem[address] into the data latch on the edge (LOW_LATENCY: visible next cycle); i_enable_mem=0 holds the latch.
REQ-012 i_rsta_mem=1 clears the data latch to 0 (priority over read) and sets o_reset_ack_mem=1 next cycle; otherwise o_reset_ack_mem=0.
REQ-013 o_instruction = 0 (NOP) when i_control_mux_ouput=1, else the data latch (combinational mux).
REQ-014 HALT = all-ones word; halted when the data latch (pre-mux) equals HALT; halted blocks PC update regardless of enable or branch.
REQ-015 o_led_mem registered: 1 for the cycle after each accepted write, else 0.
REQ-016 Simultaneous PC update and debug write to the PC address: write takes effect; PC updates normally.

Reset
REQ-017 i_soft_reset=1 at an edge: PC=0, data latch=0, o_led_mem=0, o_reset_ack_mem=0; memory contents preserved; reset overrides all other inputs.

Configuration
REQ-018 Macro TOP_IF_HALT_DETECT_EN: defined -> REQ-014 halt detection active; undefined -> never halted, PC follows REQ-008 only.

Verification
REQ-019 Reset, then enable PC 4 cycles with mux_PC=0 -> o_contador_programa 0,1,2,3,4; PLUS_4 = PC+1.
REQ-020 Addr-mux=1, write 5@1, 2@2, 5@4; addr-mux=0, read PC=1,2,4 -> o_instruction 5,2,5 one cycle after address; o_led_mem pulses after each write.
REQ-021 Write HALT @10, branch_dir=10, mux_PC=1, enable PC -> PC=10, o_instruction=FFFFFFFF, PC holds while enable=1 (macro defined); advances to branch_dir each cycle when undefined.
REQ-022 i_control_mux_ouput=1 with memory word 5 latched -> o_instruction=0; release -> 5.
REQ-023 PC=2047, enable, mux_PC=0 -> PC=0; i_rsta_mem=1 -> latch 0, o_reset_ack_mem=1 next cycle.
REQ-024 Assert i_soft_reset mid-run (PC=7) -> PC=0 next edge; previously written words still read back unchanged.

Source files
------------

// File: rtl/top_if_stage.sv
// Instruction-fetch stage: PC register, single-port program memory with a debug load port and
// NOP/HALT handling. Define TOP_IF_HALT_DETECT_EN to stall the PC while a HALT word is latched.
module top_if_stage #(
   parameter int    RAM_WIDTH_PROGRAMA       = 32,
   parameter string RAM_PERFORMANCE_PROGRAMA = "LOW_LATENCY",
   parameter string INIT_FILE_PROGRAMA       = "",
   parameter int    RAM_DEPTH_PROGRAMA       = 2048,
   parameter int    CANT_BITS_ADDR           = 11
) (
   input  logic                          i_clock,
   input  logic                          i_soft_reset,
   input  logic                          i_enable_contador_PC,
   input  logic                          i_enable_mem,
   input  logic                          i_write_read_mem,
   input  logic                          i_rsta_mem,
   input  logic                          i_regcea_mem,
   input  logic [CANT_BITS_ADDR-1:0]     i_addr_mem_programa,
   input  logic [RAM_WIDTH_PROGRAMA-1:0] i_data_mem_programa,
   input  logic                          i_control_mux_PC,
   input  logic                          i_control_mux_addr_mem,
   input  logic                          i_control_mux_ouput,
   input  logic [CANT_BITS_ADDR-1:0]     i_branch_dir,
   output logic [RAM_WIDTH_PROGRAMA-1:0] o_instruction,
   output logic [CANT_BITS_ADDR-1:0]     o_direccion_PC_PLUS_4,
   output logic [CANT_BITS_ADDR-1:0]     o_contador_programa,
   output logic                          o_led_mem,
   output logic                          o_reset_ack_mem
);

   localparam logic [RAM_WIDTH_PROGRAMA-1:0] HALT_WORD = '1;

   logic [RAM_WIDTH_PROGRAMA-1:0] mem [RAM_DEPTH_PROGRAMA];

   logic [CANT_BITS_ADDR-1:0]     pc_q, pc_d, pc_plus, mem_addr;
   logic [RAM_WIDTH_PROGRAMA-1:0] data_out;
   logic                          halted;
   logic                          wr_en, rd_en;
   logic                          led_q, ack_q;

   assign pc_plus  = pc_q + CANT_BITS_ADDR'(1);
   assign mem_addr = i_control_mux_addr_mem ? i_addr_mem_programa : pc_q;
   // Reset suppresses the memory port so a pending write cannot corrupt the program.
   assign wr_en    = !i_soft_reset && i_enable_mem && i_write_read_mem;
   assign rd_en    = i_enable_mem && !i_write_read_mem;

`ifdef TOP_IF_HALT_DETECT_EN
   assign halted = (data_out == HALT_WORD);
`else
   assign halted = 1'b0;
`endif

   always_comb begin
      pc_d = pc_q;
      if (i_enable_contador_PC && !halted) begin
         pc_d = i_control_mux_PC ? i_branch_dir : pc_plus;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_soft_reset) begin
         pc_q  <= '0;
         led_q <= 1'b0;
         ack_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         led_q <= wr_en;
         ack_q <= i_rsta_mem;
      end
   end

   // Array kept out of the reset domain so program contents survive a soft reset.
   always_ff @(posedge i_clock) begin
      if (wr_en) begin
         mem[mem_addr] <= i_data_mem_programa;
      end
   end

   if (RAM_PERFORMANCE_PROGRAMA == "HIGH_PERFORMANCE") begin : g_high_perf
      logic [RAM_WIDTH_PROGRAMA-1:0] ram_data_q, out_q;

      always_ff @(posedge i_clock) begin
         if (i_soft_reset) begin
            ram_data_q <= '0;
            out_q      <= '0;
         end else begin
            if (rd_en) begin
               ram_data_q <= mem[mem_addr];
            end
            if (i_rsta_mem) begin
               out_q <= '0;
            end else if (i_regcea_mem) begin
               out_q <= ram_data_q;
            end
         end
      end

      assign data_out = out_q;
   end else begin : g_low_latency
      logic [RAM_WIDTH_PROGRAMA-1:0] ram_data_q;
      logic                          unused_regcea;

      assign unused_regcea = i_regcea_mem;

      always_ff @(posedge i_clock) begin
         if (i_soft_reset || i_rsta_mem) begin
            ram_data_q <= '0;
         end else if (rd_en) begin
            ram_data_q <= mem[mem_addr];
         end
      end

      assign data_out = ram_data_q;
   end

   assign o_instruction         = i_control_mux_ouput ? '0 : data_out;
   assign o_direccion_PC_PLUS_4 = pc_plus;
   assign o_contador_programa   = pc_q;
   assign o_led_mem             = led_q;
   assign o_reset_ack_mem       = ack_q;

endmodule

// File: tb/tb_top_if_stage.sv
// Directed bench for top_if_stage: a per-cycle vector table plus hand sequences for PC wrap,
// HALT stalling (TOP_IF_HALT_DETECT_EN aware) and soft reset with memory retention.
module tb_top_if_stage;

   logic        clk = 1'b0;
   logic        rst, en_pc, en_mem, wr, rsta, regcea, mux_pc, mux_addr, mux_out;
   logic [10:0] addr, branch;
   logic [31:0] data;
   logic [31:0] instr;
   logic [10:0] plus4, pc;
   logic        led, ack;

`ifdef TOP_IF_HALT_DETECT_EN
   localparam bit HaltEn = 1'b1;
`else
   localparam bit HaltEn = 1'b0;
`endif

   typedef struct {
      logic        rst, en_pc, en_mem, wr, rsta, mux_pc, mux_addr, mux_out;
      logic [10:0] addr;
      logic [31:0] data;
      logic [10:0] branch;
      logic [10:0] e_pc;
      logic [31:0] e_instr;
      logic        e_led, e_ack;
   } vec_t;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   top_if_stage dut (
      .i_clock               (clk),
      .i_soft_reset          (rst),
      .i_enable_contador_PC  (en_pc),
      .i_enable_mem          (en_mem),
      .i_write_read_mem      (wr),
      .i_rsta_mem            (rsta),
      .i_regcea_mem          (regcea),
      .i_addr_mem_programa   (addr),
      .i_data_mem_programa   (data),
      .i_control_mux_PC      (mux_pc),
      .i_control_mux_addr_mem(mux_addr),
      .i_control_mux_ouput   (mux_out),
      .i_branch_dir          (branch),
      .o_instruction         (instr),
      .o_direccion_PC_PLUS_4 (plus4),
      .o_contador_programa   (pc),
      .o_led_mem             (led),
      .o_reset_ack_mem       (ack)
   );

   function automatic vec_t mk(input logic r, ep, em, w, ra, mp, ma, mo,
                               input logic [10:0] a, input logic [31:0] d,
                               input logic [10:0] b, input logic [10:0] xpc,
                               input logic [31:0] xins, input logic xled, xack);
      vec_t v;
      v.rst = r; v.en_pc = ep; v.en_mem = em; v.wr = w; v.rsta = ra;
      v.mux_pc = mp; v.mux_addr = ma; v.mux_out = mo;
      v.addr = a; v.data = d; v.branch = b;
      v.e_pc = xpc; v.e_instr = xins; v.e_led = xled; v.e_ack = xack;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Drive one cycle's inputs, clock once, then sample 1 ns after the edge.
   task automatic step(input vec_t v);
      rst = v.rst; en_pc = v.en_pc; en_mem = v.en_mem; wr = v.wr; rsta = v.rsta;
      mux_pc = v.mux_pc; mux_addr = v.mux_addr; mux_out = v.mux_out;
      addr = v.addr; data = v.data; branch = v.branch;
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input vec_t v);
      logic [10:0] exp_plus;
      exp_plus = v.e_pc + 11'd1;
      chk({tag, "_pc"},    32'(pc),    32'(v.e_pc));
      chk({tag, "_plus4"}, 32'(plus4), 32'(exp_plus));
      chk({tag, "_instr"}, instr,      v.e_instr);
      chk({tag, "_led"},   32'(led),   32'(v.e_led));
      chk({tag, "_ack"},   32'(ack),   32'(v.e_ack));
   endtask

   vec_t tbl[$];
   vec_t v;

   initial begin
      regcea = 1'b0;
      //                 rst ep em wr ra mp ma mo addr data      br    pc    instr     led ack
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0,        0,    0,    0,        0, 0));
      for (int k = 1; k <= 4; k++)
         tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,      0,    11'(k), 0,      0, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,  0,        0,    0,    0,        0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 1,  5,        0,    0,    0,        1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 2,  2,        0,    0,    0,        1, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 4,  5,        0,    0,    0,        1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0,        0,    0,    0,        0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0,  0,        1,    1,    0,        0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0,  0,        0,    1,    5,        0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0,  0,        2,    2,    5,        0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0,  0,        0,    2,    2,        0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0,  0,        4,    4,    2,        0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0,  0,        0,    4,    5,        0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  0,        0,    4,    0,        0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0,        0,    4,    5,        0, 0));
      // Write leaves the read latch untouched.
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 3,  9,        0,    4,    5,        1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0,  0,        0,    4,    0,        0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0,        0,    4,    0,        0, 0));
      // PC advance and write to the PC address in the same cycle.
      tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0,  32'h77,   0,    5,    0,        1, 0));
      tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0,  0,        4,    4,    0,        0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0,  0,        0,    4,    32'h77,   0, 0));
      // Latch reset wins over a simultaneous read.
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0,  0,        0,    4,    0,        0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  0,        0,    4,    0,        0, 0));

      foreach (tbl[i]) begin
         step(tbl[i]);
         check_all($sformatf("vec%0d", i), tbl[i]);
      end

      // PC wrap at the top of the address space.
      step(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2047, 0, 0, 0, 0));
      chk("wrap_pc", 32'(pc), 2047);
      chk("wrap_plus4", 32'(plus4), 0);
      step(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("wrap_pc0", 32'(pc), 0);
      chk("wrap_plus4_1", 32'(plus4), 1);

      // HALT stalls the PC only when halt detection is compiled in.
      step(mk(0, 0, 1, 1, 0, 0, 1, 0, 10, 32'hFFFF_FFFF, 0, 0, 0, 0, 0));
      chk("halt_wr_led", 32'(led), 1);
      step(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 10, 0, 0, 0, 0));
      chk("halt_br_pc", 32'(pc), 10);
      step(mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 10, 0, 0, 0, 0));
      chk("halt_pc", 32'(pc), 10);
      chk("halt_instr", instr, 32'hFFFF_FFFF);
      for (int k = 0; k < 2; k++) begin
         step(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0));
         chk($sformatf("halt_hold%0d", k), 32'(pc), HaltEn ? 10 : 3);
      end
      step(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      chk("halt_clr_instr", instr, 0);
      chk("halt_clr_ack", 32'(ack), 1);
      step(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 7, 0, 0, 0, 0));
      chk("pre_rst_pc", 32'(pc), 7);

      // Soft reset overrides every other input, including a pending write.
      step(mk(1, 1, 1, 1, 1, 1, 1, 0, 1, 32'h1234, 9, 0, 0, 0, 0));
      chk("srst_pc", 32'(pc), 0);
      chk("srst_instr", instr, 0);
      chk("srst_led", 32'(led), 0);
      chk("srst_ack", 32'(ack), 0);
      step(mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
      chk("keep_m1", instr, 5);
      step(mk(0, 0, 1, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0));
      chk("keep_m2", instr, 2);
      step(mk(0, 0, 1, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0, 0, 0));
      chk("keep_m4", instr, 32'h77);
      step(mk(0, 0, 1, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0));
      chk("keep_m3", instr, 9);
      chk("keep_pc", 32'(pc), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
